// File: rtl/ucsbece154_icache_rr.sv
`timescale 1ns/1ps
// Set-associative instruction cache with burst refill, early restart,
// per-set round-robin replacement, whole-cache flush and hit/miss counters.
module ucsbece154_icache_rr #(
  parameter int unsigned NUM_SETS    = 8,
  parameter int unsigned NUM_WAYS    = 4,
  parameter int unsigned BLOCK_WORDS = 4,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 ReadEnable,
  input  logic [31:0]          ReadAddress,
  input  logic                 Flush,
  output logic [31:0]          Instruction,
  output logic                 Ready,
  output logic                 Busy,
  output logic [31:0]          MemReadAddress,
  output logic                 MemReadRequest,
  input  logic [31:0]          MemDataIn,
  input  logic                 MemDataReady,
  output logic [CNT_WIDTH-1:0] HitCount,
  output logic [CNT_WIDTH-1:0] MissCount
);

  localparam int unsigned WOFF  = $clog2(BLOCK_WORDS);
  localparam int unsigned SET_W = $clog2(NUM_SETS);
  localparam int unsigned WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int unsigned TAG_W = 30 - WOFF - SET_W;

  typedef enum logic {S_IDLE, S_FILL} state_t;

  state_t state_q, state_d;

  // Cache storage
  logic [NUM_WAYS-1:0] valid_q  [NUM_SETS];
  logic [WAY_W-1:0]    rr_ptr_q [NUM_SETS];
  logic [TAG_W-1:0]    tag_q    [NUM_SETS][NUM_WAYS];
  logic [31:0]         data_q   [NUM_SETS][NUM_WAYS][BLOCK_WORDS];
  logic [31:0]         line_buf [BLOCK_WORDS];

  // Outstanding-miss context
  logic [SET_W-1:0] fill_set;
  logic [TAG_W-1:0] fill_tag;
  logic [WOFF-1:0]  fill_word;
  logic [WAY_W-1:0] fill_way;
  logic             fill_by_ptr;
  logic             fill_flushed;
  logic [WOFF-1:0]  beat_q;

  logic [WOFF-1:0]  req_word;
  logic [SET_W-1:0] req_set;
  logic [TAG_W-1:0] req_tag;
  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] vic_way;
  logic             vic_by_ptr;
  logic             accept;
  logic             beat_fire;
  logic             last_beat;
  logic             unused_addr_bits;

  assign req_word         = ReadAddress[WOFF+1:2];
  assign req_set          = ReadAddress[WOFF+1+SET_W:WOFF+2];
  assign req_tag          = ReadAddress[31:WOFF+2+SET_W];
  assign unused_addr_bits = ^ReadAddress[1:0];

  assign Busy           = (state_q == S_FILL);
  assign MemReadRequest = (state_q == S_FILL);

  // Tag compare and victim choice for the addressed set
  always_comb begin
    hit        = 1'b0;
    hit_way    = '0;
    vic_way    = rr_ptr_q[req_set];
    vic_by_ptr = 1'b1;
    for (int w = int'(NUM_WAYS) - 1; w >= 0; w--) begin
      if (!valid_q[req_set][w]) begin
        vic_way    = WAY_W'(w);
        vic_by_ptr = 1'b0;
      end
    end
    for (int w = 0; w < int'(NUM_WAYS); w++) begin
      if (valid_q[req_set][w] && (tag_q[req_set][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Next-state and per-cycle control strobes
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    beat_fire = 1'b0;
    last_beat = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ReadEnable && !Flush) begin
          accept = 1'b1;
          if (!hit) state_d = S_FILL;
        end
      end
      S_FILL: begin
        if (MemDataReady) begin
          beat_fire = 1'b1;
          if (beat_q == '1) begin
            last_beat = 1'b1;
            state_d   = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Core response, miss context, beat counter and performance counters
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Instruction    <= '0;
      Ready          <= 1'b0;
      MemReadAddress <= '0;
      HitCount       <= '0;
      MissCount      <= '0;
      beat_q         <= '0;
      fill_set       <= '0;
      fill_tag       <= '0;
      fill_word      <= '0;
      fill_way       <= '0;
      fill_by_ptr    <= 1'b0;
      fill_flushed   <= 1'b0;
    end else begin
      Ready <= 1'b0;
      if (accept && hit) begin
        Instruction <= data_q[req_set][hit_way][req_word];
        Ready       <= 1'b1;
        HitCount    <= HitCount + CNT_WIDTH'(1);
      end
      if (accept && !hit) begin
        fill_set       <= req_set;
        fill_tag       <= req_tag;
        fill_word      <= req_word;
        fill_way       <= vic_way;
        fill_by_ptr    <= vic_by_ptr;
        fill_flushed   <= 1'b0;
        beat_q         <= '0;
        MemReadAddress <= {ReadAddress[31:WOFF+2], {(WOFF+2){1'b0}}};
        MissCount      <= MissCount + CNT_WIDTH'(1);
      end
      if (beat_fire) begin
        beat_q <= beat_q + WOFF'(1);
        if (beat_q == fill_word) begin
          Instruction <= MemDataIn;
          Ready       <= 1'b1;
        end
      end
      if ((state_q == S_FILL) && Flush) fill_flushed <= 1'b1;
    end
  end

  // Valid bits and round-robin pointers; a flush seen during the fill wins
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int s = 0; s < int'(NUM_SETS); s++) begin
        valid_q[s]  <= '0;
        rr_ptr_q[s] <= '0;
      end
    end else begin
      if (Flush) begin
        for (int s = 0; s < int'(NUM_SETS); s++) valid_q[s] <= '0;
      end
      if (last_beat) begin
        valid_q[fill_set][fill_way] <= !(fill_flushed || Flush);
        if (fill_by_ptr) begin
          rr_ptr_q[fill_set] <= (NUM_WAYS == 1) ? '0 : rr_ptr_q[fill_set] + WAY_W'(1);
        end
      end
    end
  end

  // Line buffer and line/tag write-back on the final beat
  always_ff @(posedge Clk) begin
    if (beat_fire) line_buf[beat_q] <= MemDataIn;
    if (last_beat && !Reset) begin
      tag_q[fill_set][fill_way] <= fill_tag;
      for (int w = 0; w < int'(BLOCK_WORDS) - 1; w++) begin
        data_q[fill_set][fill_way][w] <= line_buf[w];
      end
      data_q[fill_set][fill_way][BLOCK_WORDS-1] <= MemDataIn;
    end
  end

endmodule
